// File: rtl/control_temporizador_pkg.sv
// Shared state encoding for the timer sequencer, so display and alarm
// blocks decode ESTADO identically.
package control_temporizador_pkg;

    localparam int ESTADO_W = 2;

    typedef enum logic [ESTADO_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSA = 2'd2,
        HECHO = 2'd3
    } estado_t;

endpackage

// File: rtl/control_temporizador_divisor_tick.sv
// Modulo-DIV prescaler: TICK is high on the enabled cycle where the
// count sits at DIV-1, and the count wraps to 0 on that same edge.
module divisor_tick #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign TICK = EN && (cnt == ULTIMO);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= '0;
        end else if (CLR) begin
            cnt <= '0;
        end else if (EN) begin
            cnt <= (cnt == ULTIMO) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/control_temporizador.sv
// Down-counting timer sequencer: load, run on prescaled ticks, pause/resume,
// clear, and a one-cycle FIN pulse when the count expires.
module control_temporizador
    import control_temporizador_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int ANCHO = 8
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                START,
    input  logic                PAUSE,
    input  logic                CLEAR,
    input  logic [ANCHO-1:0]    DURACION,
    output logic [ANCHO-1:0]    CUENTA,
    output logic [ESTADO_W-1:0] ESTADO,
    output logic                ACTIVO,
    output logic                FIN
);

    estado_t          estado;
    logic [ANCHO-1:0] cuenta;
    logic             fin;
    logic             activo;

    logic carga;
    logic pre_en;
    logic pre_clr;
    logic tick;

    // A load only happens when neither CLEAR nor PAUSE outranks START.
    assign carga   = !CLEAR && !PAUSE && START && (DURACION != '0) &&
                     ((estado == IDLE) || (estado == HECHO));
    // The prescaler must not advance on a pause edge so a pending tick survives.
    assign pre_en  = (estado == RUN) && !PAUSE && !CLEAR;
    assign pre_clr = CLEAR || carga;

    divisor_tick #(.DIV(DIV)) u_divisor (
        .CLK  (CLK),
        .RSTn (RSTn),
        .EN   (pre_en),
        .CLR  (pre_clr),
        .TICK (tick)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            estado <= IDLE;
            cuenta <= '0;
            fin    <= 1'b0;
            activo <= 1'b0;
        end else begin
            fin <= 1'b0;
            if (CLEAR) begin
                estado <= IDLE;
                cuenta <= '0;
                activo <= 1'b0;
            end else begin
                case (estado)
                    IDLE, HECHO: begin
                        if (carga) begin
                            estado <= RUN;
                            cuenta <= DURACION;
                            activo <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (PAUSE) begin
                            estado <= PAUSA;
                            activo <= 1'b0;
                        end else if (tick && (cuenta != '0)) begin
                            if (cuenta == ANCHO'(1)) begin
                                estado <= HECHO;
                                cuenta <= '0;
                                fin    <= 1'b1;
                                activo <= 1'b0;
                            end else begin
                                cuenta <= cuenta - ANCHO'(1);
                            end
                        end
                    end
                    PAUSA: begin
                        if (START && !PAUSE) begin
                            estado <= RUN;
                            activo <= 1'b1;
                        end
                    end
                    default: begin
                        estado <= IDLE;
                        activo <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign CUENTA = cuenta;
    assign ESTADO = estado;
    assign ACTIVO = activo;
    assign FIN    = fin;

endmodule

// File: tb/tb_control_temporizador.sv
// Bench for control_temporizador: vector table, hand-written corner
// sequences, then random stimulus against a run-cycle based model.
module tb_control_temporizador;
    import control_temporizador_pkg::*;

    localparam int DIV   = 4;
    localparam int ANCHO = 8;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             START = 1'b0;
    logic             PAUSE = 1'b0;
    logic             CLEAR = 1'b0;
    logic [ANCHO-1:0] DURACION = '0;
    logic [ANCHO-1:0] CUENTA;
    logic [1:0]       ESTADO;
    logic             ACTIVO;
    logic             FIN;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    control_temporizador #(.DIV(DIV), .ANCHO(ANCHO)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .START    (START),
        .PAUSE    (PAUSE),
        .CLEAR    (CLEAR),
        .DURACION (DURACION),
        .CUENTA   (CUENTA),
        .ESTADO   (ESTADO),
        .ACTIVO   (ACTIVO),
        .FIN      (FIN)
    );

    typedef struct {
        bit   start;
        bit   pause;
        bit   clear;
        int   dur;
        int   est;
        int   cta;
        bit   fin;
    } vec_t;

    vec_t tbl[$];

    // Model state: mode 0..3, loaded duration, RUN cycles since load.
    int m_mode = 0;
    int m_dur  = 0;
    int m_run  = 0;
    bit m_fin  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int est, input int cta, input bit fin);
        check({tag, ".estado"}, 32'(ESTADO), 32'(est));
        check({tag, ".cuenta"}, 32'(CUENTA), 32'(cta));
        check({tag, ".fin"},    32'(FIN),    32'(fin));
        check({tag, ".activo"}, 32'(ACTIVO), 32'(est == 1));
    endtask

    task automatic drive(input bit s, input bit p, input bit c, input int d);
        START    = s;
        PAUSE    = p;
        CLEAR    = c;
        DURACION = ANCHO'(d);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic void add(input bit s, input bit p, input bit c, input int d,
                                input int est, input int cta, input bit fin);
        vec_t v;
        v.start = s; v.pause = p; v.clear = c; v.dur = d;
        v.est = est; v.cta = cta; v.fin = fin;
        tbl.push_back(v);
    endfunction

    function automatic void model_edge(input bit s, input bit p, input bit c, input int d);
        m_fin = 1'b0;
        if (c) begin
            m_mode = 0; m_dur = 0; m_run = 0;
        end else if (m_mode == 1) begin
            if (p) begin
                m_mode = 2;
            end else begin
                m_run++;
                if (m_run == m_dur * DIV) begin
                    m_mode = 3;
                    m_fin  = 1'b1;
                end
            end
        end else if (m_mode == 2) begin
            if (s && !p) m_mode = 1;
        end else if (s && !p && d != 0) begin
            m_mode = 1; m_dur = d; m_run = 0;
        end
    endfunction

    function automatic int model_cuenta();
        if (m_mode == 0 || m_mode == 3) return 0;
        return m_dur - m_run / DIV;
    endfunction

    initial begin
        // Reset
        step();
        step();
        expect_out("reset", 0, 0, 0);
        RSTn = 1'b1;
        step();
        expect_out("post_reset", 0, 0, 0);

        // Basic countdown from 3, then reload from HECHO, clear, zero-duration start
        add(1, 0, 0, 3, 1, 3, 0);
        for (int i = 1; i <= 3; i++) add(0, 0, 0, 0, 1, 3, 0);
        for (int i = 4; i <= 7; i++) add(0, 0, 0, 0, 1, 2, 0);
        for (int i = 8; i <= 11; i++) add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 3, 0, 1);
        add(0, 0, 0, 0, 3, 0, 0);
        add(1, 0, 0, 5, 1, 5, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].start, tbl[i].pause, tbl[i].clear, tbl[i].dur);
            step();
            expect_out($sformatf("vec%0d", i), tbl[i].est, tbl[i].cta, tbl[i].fin);
        end

        // Asynchronous reset mid-RUN takes effect between edges
        drive(1, 0, 0, 3);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        expect_out("pre_async", 1, 3, 0);
        #2 RSTn = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0);
        step();
        RSTn = 1'b1;
        step();
        expect_out("after_async", 0, 0, 0);

        // Pause at k+6 for 10 cycles, resume, FIN at k+23
        drive(1, 0, 0, 3);
        step();
        expect_out("p3_k", 1, 3, 0);
        drive(0, 0, 0, 0);
        repeat (5) step();
        expect_out("p3_k5", 1, 2, 0);
        drive(0, 1, 0, 0);
        for (int i = 6; i <= 15; i++) begin
            step();
            expect_out($sformatf("p3_pausa%0d", i), 2, 2, 0);
        end
        drive(1, 0, 0, 0);
        step();
        expect_out("p3_resume", 1, 2, 0);
        drive(0, 0, 0, 0);
        for (int i = 17; i <= 23; i++) begin
            step();
            if (i < 23) expect_out($sformatf("p3_k%0d", i), 1, (i < 19) ? 2 : 1, 0);
            else        expect_out("p3_fin", 3, 0, 1);
        end
        step();
        expect_out("p3_after", 3, 0, 0);

        // Pause coincident with the final tick
        drive(1, 0, 0, 1);
        step();
        expect_out("p4_load", 1, 1, 0);
        drive(0, 0, 0, 0);
        repeat (3) step();
        expect_out("p4_k3", 1, 1, 0);
        drive(0, 1, 0, 0);
        step();
        expect_out("p4_pause_tick", 2, 1, 0);
        step();
        expect_out("p4_held", 2, 1, 0);
        drive(1, 0, 0, 0);
        step();
        expect_out("p4_resume", 1, 1, 0);
        drive(0, 0, 0, 0);
        step();
        expect_out("p4_fin", 3, 0, 1);

        // CLEAR during RUN, then a fresh one-tick run
        drive(1, 0, 0, 3);
        step();
        expect_out("p5_load", 1, 3, 0);
        drive(0, 0, 0, 0);
        repeat (5) step();
        expect_out("p5_k5", 1, 2, 0);
        drive(0, 0, 1, 0);
        step();
        expect_out("p5_clear", 0, 0, 0);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("p5_idle%0d", i), 0, 0, 0);
        end
        drive(1, 0, 0, 1);
        step();
        expect_out("p5_j", 1, 1, 0);
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            expect_out($sformatf("p5_j%0d", i), 1, 1, 0);
        end
        step();
        expect_out("p5_fin", 3, 0, 1);

        // Random stimulus against the model
        RSTn = 1'b0;
        drive(0, 0, 0, 0);
        step();
        RSTn = 1'b1;
        m_mode = 0; m_dur = 0; m_run = 0; m_fin = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            bit s, p, c;
            int d;
            s = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 59) == 0);
            d = int'($urandom_range(0, 5));
            drive(s, p, c, d);
            step();
            model_edge(s, p, c, d);
            expect_out($sformatf("rnd%0d", n), m_mode, model_cuenta(), m_fin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
